// File: rtl/spi_flash_responder_if.sv
// Bus bundle between the flash SPI master and the flash responder.
// The master drives the SPI pins. The responder drives MISO and the decode status.
interface spi_flash_responder_if;
  logic       spi_clk;
  logic       spi_cs;
  logic       spi_di;
  logic       spi_do;
  logic       cmd_valid;
  logic [7:0] cmd_byte;
  logic       wel;

  modport master (
    output spi_clk, spi_cs, spi_di,
    input  spi_do, cmd_valid, cmd_byte, wel
  );

  modport slave (
    input  spi_clk, spi_cs, spi_di,
    output spi_do, cmd_valid, cmd_byte, wel
  );
endinterface

// File: rtl/spi_flash_responder.sv
// SPI-flash slave (mode 0, MSB first) that is oversampled on sclk.
// It serves read (03), page program (02), JEDEC ID (9F), read status (05),
// write enable (06) and write disable (04) from a small internal byte array.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | CS high, or waiting for a fresh CS falling edge after reset
// CMD    | shifting in the opcode byte
// ADDR   | shifting in the 24-bit address (3 bytes)
// READ   | streaming mem[addr], addr auto-increments and wraps
// PROG   | writing received bytes to mem[addr] when wel is set
// STAT   | repeating the status byte {6'b0, wel, 1'b0}
// ID     | MFG_ID, DEV_ID[15:8], DEV_ID[7:0], then 8'h00 forever
// IGNORE | unknown or write-enable opcode, MISO held low until CS rises
module spi_flash_responder #(
  parameter int          DEPTH_W = 8,
  parameter logic [7:0]  MFG_ID  = 8'hEF,
  parameter logic [15:0] DEV_ID  = 16'h4016
) (
  input logic               sclk,
  input logic               srst,
  spi_flash_responder_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_W;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, READ, PROG, STAT, ID, IGNORE} state_t;

  state_t               state;
  logic [1:0]           clk_sync, cs_sync, di_sync;
  logic                 clk_prev;
  logic                 armed;
  logic [2:0]           bit_cnt;
  logic [6:0]           shift_in;
  logic [7:0]           shift_out;
  logic                 miso;
  logic                 cmd_pulse;
  logic [7:0]           cmd_reg;
  logic                 wel_reg;
  logic [DEPTH_W-1:0]   addr;
  logic [1:0]           addr_cnt;
  logic                 is_read;
  logic [1:0]           id_idx;
  logic                 prog_hit;

  // The array stores (data ^ address). All-zero power-up storage therefore
  // reads back as mem[a] = a, and srst never touches it.
  logic [7:0]           mem_x [0:DEPTH-1];

  logic                 rise, fall, cs_high, byte_done;
  logic [7:0]           rx_byte, status, rd_at_shift, rd_at_inc;
  logic [DEPTH_W-1:0]   addr_shift, addr_inc;

  assign rise        = clk_sync[1] & ~clk_prev;
  assign fall        = ~clk_sync[1] & clk_prev;
  assign cs_high     = cs_sync[1];
  assign rx_byte     = {shift_in, di_sync[1]};
  assign byte_done   = rise && (bit_cnt == 3'd7);
  assign status      = {6'b0, wel_reg, 1'b0};
  assign addr_shift  = DEPTH_W'({addr, rx_byte});
  assign addr_inc    = addr + DEPTH_W'(1);
  assign rd_at_shift = mem_x[addr_shift] ^ 8'(addr_shift);
  assign rd_at_inc   = mem_x[addr_inc] ^ 8'(addr_inc);

  assign bus.spi_do    = miso;
  assign bus.cmd_valid = cmd_pulse;
  assign bus.cmd_byte  = cmd_reg;
  assign bus.wel       = wel_reg;

  // Synchronize the SPI pins and keep the previous clock level for edge detection.
  // CS resets to "low" so that a real high level must be seen before re-arming.
  always_ff @(posedge sclk) begin
    if (srst) begin
      clk_sync <= 2'b00;
      cs_sync  <= 2'b00;
      di_sync  <= 2'b00;
      clk_prev <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[0], bus.spi_clk};
      cs_sync  <= {cs_sync[0], bus.spi_cs};
      di_sync  <= {di_sync[0], bus.spi_di};
      clk_prev <= clk_sync[1];
    end
  end

  // Command decoder, shifters, write-enable latch and array write port.
  always_ff @(posedge sclk) begin
    if (srst) begin
      state     <= IDLE;
      armed     <= 1'b0;
      bit_cnt   <= 3'd0;
      shift_in  <= 7'd0;
      shift_out <= 8'd0;
      miso      <= 1'b0;
      cmd_pulse <= 1'b0;
      cmd_reg   <= 8'h00;
      wel_reg   <= 1'b0;
      addr      <= '0;
      addr_cnt  <= 2'd0;
      is_read   <= 1'b0;
      id_idx    <= 2'd0;
      prog_hit  <= 1'b0;
    end else begin
      cmd_pulse <= 1'b0;
      if (state != IDLE && cs_high) begin
        state     <= IDLE;
        bit_cnt   <= 3'd0;
        shift_out <= 8'd0;
        miso      <= 1'b0;
        if (prog_hit) wel_reg <= 1'b0;
        prog_hit  <= 1'b0;
      end else if (state == IDLE) begin
        bit_cnt   <= 3'd0;
        shift_out <= 8'd0;
        miso      <= 1'b0;
        addr_cnt  <= 2'd0;
        id_idx    <= 2'd0;
        prog_hit  <= 1'b0;
        if (cs_high)    armed <= 1'b1;
        else if (armed) state <= CMD;
      end else begin
        if (rise) begin
          shift_in <= rx_byte[6:0];
          bit_cnt  <= bit_cnt + 3'd1;
        end else if (fall && state != IGNORE) begin
          miso      <= shift_out[7];
          shift_out <= {shift_out[6:0], 1'b0};
        end
        if (byte_done) begin
          case (state)
            CMD: begin
              cmd_reg   <= rx_byte;
              cmd_pulse <= 1'b1;
              case (rx_byte)
                8'h03: begin state <= ADDR; is_read <= 1'b1; addr_cnt <= 2'd0; end
                8'h02: begin state <= ADDR; is_read <= 1'b0; addr_cnt <= 2'd0; end
                8'h9F: begin state <= ID; shift_out <= MFG_ID; id_idx <= 2'd1; end
                8'h05: begin state <= STAT; shift_out <= status; end
                8'h06: begin state <= IGNORE; wel_reg <= 1'b1; end
                8'h04: begin state <= IGNORE; wel_reg <= 1'b0; end
                default: state <= IGNORE;
              endcase
            end
            ADDR: begin
              addr <= addr_shift;
              if (addr_cnt == 2'd2) begin
                if (is_read) begin
                  state     <= READ;
                  shift_out <= rd_at_shift;
                end else begin
                  state <= PROG;
                end
              end else begin
                addr_cnt <= addr_cnt + 2'd1;
              end
            end
            READ: begin
              addr      <= addr_inc;
              shift_out <= rd_at_inc;
            end
            PROG: begin
              if (wel_reg) begin
                mem_x[addr] <= rx_byte ^ 8'(addr);
                addr        <= addr_inc;
                prog_hit    <= 1'b1;
              end
            end
            STAT: shift_out <= status;
            ID: begin
              case (id_idx)
                2'd1:    shift_out <= DEV_ID[15:8];
                2'd2:    shift_out <= DEV_ID[7:0];
                default: shift_out <= 8'h00;
              endcase
              if (id_idx != 2'd3) id_idx <= id_idx + 2'd1;
            end
            default: ;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_flash_responder.sv
// Bench for spi_flash_responder: directed flash scenarios followed by random
// command traffic, all compared against a byte-array flash model.
module tb_spi_flash_responder;
  localparam int HALF = 6;

  logic sclk = 1'b0;
  logic srst;
  spi_flash_responder_if bus();

  spi_flash_responder #(.DEPTH_W(8), .MFG_ID(8'hEF), .DEV_ID(16'h4016)) dut (
    .sclk(sclk),
    .srst(srst),
    .bus (bus)
  );

  always #5 sclk = ~sclk;

  int compared   = 0;
  int mismatched = 0;
  int pulses     = 0;

  logic [7:0] ref_mem [256];
  logic       ref_wel;
  logic [7:0] pbuf [4];

  // Count sclk cycles with cmd_valid high.
  always @(negedge sclk) if (bus.cmd_valid === 1'b1) pulses++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < n; i++) begin
      bus.spi_di = tx[7-i];
      repeat (HALF) @(negedge sclk);
      rx = {rx[6:0], bus.spi_do};
      bus.spi_clk = 1'b1;
      repeat (HALF) @(negedge sclk);
      bus.spi_clk = 1'b0;
    end
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    spi_bits(tx, 8, rx);
  endtask

  task automatic cs_begin();
    @(negedge sclk);
    bus.spi_cs = 1'b0;
    repeat (HALF) @(negedge sclk);
  endtask

  task automatic cs_end();
    repeat (HALF) @(negedge sclk);
    bus.spi_cs = 1'b1;
    repeat (HALF + 2) @(negedge sclk);
  endtask

  task automatic send_cmd(input logic [7:0] op);
    int p0;
    logic [7:0] rx;
    p0 = pulses;
    xfer(op, rx);
    check("cmd_miso", rx, 8'h00);
    check("cmd_valid_pulses", pulses - p0, 1);
    check("cmd_byte", bus.cmd_byte, op);
  endtask

  task automatic send_addr(input logic [7:0] a);
    logic [7:0] rx;
    xfer(8'($urandom), rx);
    xfer(8'($urandom), rx);
    xfer(a, rx);
  endtask

  task automatic cmd_read(input logic [7:0] a, input int n);
    logic [7:0] rx;
    cs_begin();
    send_cmd(8'h03);
    send_addr(a);
    for (int i = 0; i < n; i++) begin
      xfer(8'($urandom), rx);
      check("read_data", rx, ref_mem[8'(a + i)]);
    end
    cs_end();
  endtask

  task automatic cmd_prog(input logic [7:0] a, input int n);
    logic [7:0] rx;
    cs_begin();
    send_cmd(8'h02);
    send_addr(a);
    for (int i = 0; i < n; i++) begin
      xfer(pbuf[i], rx);
      check("prog_miso", rx, 8'h00);
      if (ref_wel) ref_mem[8'(a + i)] = pbuf[i];
    end
    cs_end();
    if (ref_wel && n > 0) ref_wel = 1'b0;
    check("wel_after_prog", bus.wel, ref_wel);
  endtask

  task automatic cmd_status(input int n);
    logic [7:0] rx;
    cs_begin();
    send_cmd(8'h05);
    for (int i = 0; i < n; i++) begin
      xfer(8'($urandom), rx);
      check("status", rx, ref_wel ? 8'h02 : 8'h00);
    end
    cs_end();
  endtask

  task automatic cmd_id(input int n);
    logic [7:0] rx;
    logic [7:0] exp;
    cs_begin();
    send_cmd(8'h9F);
    for (int i = 0; i < n; i++) begin
      xfer(8'($urandom), rx);
      exp = (i == 0) ? 8'hEF : (i == 1) ? 8'h40 : (i == 2) ? 8'h16 : 8'h00;
      check("id_byte", rx, exp);
    end
    cs_end();
  endtask

  task automatic cmd_simple(input logic [7:0] op, input int n);
    logic [7:0] rx;
    cs_begin();
    send_cmd(op);
    for (int i = 0; i < n; i++) begin
      xfer(8'($urandom), rx);
      check("ignore_miso", rx, 8'h00);
    end
    cs_end();
    if (op == 8'h06) ref_wel = 1'b1;
    if (op == 8'h04) ref_wel = 1'b0;
    check("wel_after_cmd", bus.wel, ref_wel);
  endtask

  initial begin
    logic [7:0] rx;
    logic [7:0] a;
    int p0;
    int n;

    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i);
    ref_wel     = 1'b0;
    bus.spi_clk = 1'b0;
    bus.spi_cs  = 1'b1;
    bus.spi_di  = 1'b0;
    srst        = 1'b1;
    repeat (3) @(negedge sclk);
    check("rst_spi_do", bus.spi_do, 1'b0);
    check("rst_wel", bus.wel, 1'b0);
    check("rst_cmd_byte", bus.cmd_byte, 8'h00);
    check("rst_cmd_valid", bus.cmd_valid, 1'b0);
    srst = 1'b0;
    repeat (6) @(negedge sclk);

    // JEDEC ID
    cmd_id(4);

    // read with wrap
    cmd_read(8'hFE, 4);

    // program without write enable is discarded
    pbuf[0] = 8'h55;
    cmd_prog(8'h10, 1);
    cmd_read(8'h10, 1);

    // write enable, status, program, auto-clear of wel
    cmd_simple(8'h06, 0);
    cmd_status(2);
    pbuf[0] = 8'h55;
    pbuf[1] = 8'hAA;
    cmd_prog(8'h10, 2);
    cmd_status(1);
    cmd_read(8'h10, 2);

    // CS dropped mid address byte, next command clean
    cs_begin();
    send_cmd(8'h03);
    xfer(8'h00, rx);
    spi_bits(8'h5A, 5, rx);
    cs_end();
    cmd_id(2);

    // srst in the middle of a read stream
    cs_begin();
    send_cmd(8'h03);
    send_addr(8'hC0);
    xfer(8'h00, rx);
    check("pre_rst_read", rx, ref_mem[8'hC0]);
    repeat (4) @(negedge sclk);
    check("pre_rst_msb", bus.spi_do, ref_mem[8'hC1][7]);
    srst = 1'b1;
    @(negedge sclk);
    srst = 1'b0;
    ref_wel = 1'b0;
    check("rst_mid_spi_do", bus.spi_do, 1'b0);
    p0 = pulses;
    xfer(8'h9F, rx);
    check("post_rst_silent", rx, 8'h00);
    xfer(8'h05, rx);
    check("post_rst_silent", rx, 8'h00);
    check("post_rst_no_decode", pulses - p0, 0);
    cs_end();
    cmd_read(8'h20, 1);
    check("post_rst_wel", bus.wel, 1'b0);

    // random traffic against the model
    for (int it = 0; it < 24; it++) begin
      a = 8'($urandom);
      n = int'($urandom_range(1, 4));
      case ($urandom_range(0, 6))
        0, 1: cmd_read(a, n);
        2: begin
          for (int k = 0; k < 4; k++) pbuf[k] = 8'($urandom);
          cmd_prog(a, n);
        end
        3: cmd_simple(8'h06, 0);
        4: cmd_simple(($urandom_range(0, 1) == 0) ? 8'h04 : 8'hAB, n);
        5: cmd_status(n);
        default: cmd_id(n);
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
